// File: rtl/wisc_pkg.sv
// Shared types and constants for the writeback stage: data/register widths,
// writeback source selects, FSM state encoding and the MEM/WB register layout.
package wisc_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 16;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_HALTED   = 2'b10
  } wb_state_t;

  typedef struct packed {
    logic              valid;
    logic              regwrt;
    logic [REG_W-1:0]  wrsel;
    logic [1:0]        wbsel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
  } memwb_t;

endpackage

// File: rtl/wb_mux.sv
// Pure 4:1 writeback source mux: ALU result, load data, PC+2 or immediate.
module wb_mux
  import wisc_pkg::*;
(
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_wb
);

  always_comb begin
    o_wb = i_alu;
    case (i_sel)
      WB_SEL_ALU: o_wb = i_alu;
      WB_SEL_MEM: o_wb = i_mem;
      WB_SEL_PC:  o_wb = i_pc;
      WB_SEL_IMM: o_wb = i_imm;
      default:    o_wb = i_alu;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, source select, late-load wait and HALT retirement.
// Optional macro WB_TIMEOUT_EN bounds the late-load wait to TIMEOUT_CYCLES cycles.
module wb_stage
  import wisc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_RegWrt,
  input  logic [REG_W-1:0]  in_WrSel,
  input  logic [1:0]        in_WBSel,
  input  logic [DATA_W-1:0] in_ALUOut,
  input  logic [DATA_W-1:0] in_MemData,
  input  logic [DATA_W-1:0] in_PCInc,
  input  logic [DATA_W-1:0] in_Imm,
  input  logic              in_mem_pending,
  input  logic              in_halt,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] WB,
  output logic [REG_W-1:0]  WrSel,
  output logic              RegWrt,
  output logic              wb_stall,
  output logic              halted,
  output logic              err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_stage: TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_t r_state;
  wb_state_t w_state_nxt;
  memwb_t    r_pipe;
  memwb_t    w_pipe_nxt;
  logic      r_err;
  logic      w_err_nxt;
  logic      w_timeout;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_cnt;

  // Held at zero outside WAIT_MEM, so it always starts from zero on entry.
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_WAIT_MEM) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pipe_nxt  = r_pipe;
    w_err_nxt   = r_err;
    if (mem_done && r_state != ST_WAIT_MEM) w_err_nxt = 1'b1;
    case (r_state)
      ST_RUN: begin
        w_pipe_nxt.valid  = in_valid;
        w_pipe_nxt.regwrt = in_RegWrt;
        w_pipe_nxt.wrsel  = in_WrSel;
        w_pipe_nxt.wbsel  = in_WBSel;
        w_pipe_nxt.alu    = in_ALUOut;
        w_pipe_nxt.mem    = in_MemData;
        w_pipe_nxt.pc     = in_PCInc;
        w_pipe_nxt.imm    = in_Imm;
        // HALT wins over a pending load; the combination itself is a protocol error.
        if (in_valid && in_halt) begin
          w_state_nxt = ST_HALTED;
          if (in_mem_pending) w_err_nxt = 1'b1;
        end else if (in_valid && in_mem_pending) begin
          w_state_nxt = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_done) begin
          w_pipe_nxt.mem = mem_rdata;
          w_state_nxt    = ST_RUN;
        end else if (w_timeout) begin
          w_pipe_nxt.valid = 1'b0;
          w_err_nxt        = 1'b1;
          w_state_nxt      = ST_RUN;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pipe  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pipe  <= w_pipe_nxt;
      r_err   <= w_err_nxt;
    end
  end

  wb_mux u_wb_mux (
    .i_sel (r_pipe.wbsel),
    .i_alu (r_pipe.alu),
    .i_mem (r_pipe.mem),
    .i_pc  (r_pipe.pc),
    .i_imm (r_pipe.imm),
    .o_wb  (WB)
  );

  assign WrSel    = r_pipe.wrsel;
  assign RegWrt   = r_pipe.valid & r_pipe.regwrt & (r_state == ST_RUN);
  assign wb_stall = (r_state != ST_RUN);
  assign halted   = (r_state == ST_HALTED);
  assign err      = r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vectors, expected writes queued at issue time and
// popped by a monitor whenever RegWrt is asserted. Define WB_TIMEOUT_EN to add the timeout case.
module tb_wb_stage;
  import wisc_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_RegWrt, in_mem_pending, in_halt, mem_done;
  logic [2:0]  in_WrSel;
  logic [1:0]  in_WBSel;
  logic [15:0] in_ALUOut, in_MemData, in_PCInc, in_Imm, mem_rdata;
  logic [15:0] WB;
  logic [2:0]  WrSel;
  logic        RegWrt, wb_stall, halted, err;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_RegWrt(in_RegWrt), .in_WrSel(in_WrSel), .in_WBSel(in_WBSel),
    .in_ALUOut(in_ALUOut), .in_MemData(in_MemData), .in_PCInc(in_PCInc), .in_Imm(in_Imm),
    .in_mem_pending(in_mem_pending), .in_halt(in_halt),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .WB(WB), .WrSel(WrSel), .RegWrt(RegWrt), .wb_stall(wb_stall), .halted(halted), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [2:0] ws, input logic [1:0] sel,
                       input logic [15:0] alu, input logic [15:0] md, input logic [15:0] pc,
                       input logic [15:0] imm, input logic pend, input logic hlt);
    in_valid = v; in_RegWrt = rw; in_WrSel = ws; in_WBSel = sel;
    in_ALUOut = alu; in_MemData = md; in_PCInc = pc; in_Imm = imm;
    in_mem_pending = pend; in_halt = hlt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_wr(input logic [2:0] ws, input logic [15:0] data);
    exp_q.push_back({ws, data});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && RegWrt === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got WrSel=%0d WB=0x%0h, expected no write", WrSel, WB);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({WrSel, WB} !== e) begin
          errors++;
          $display("FAIL write_data: got WrSel=%0d WB=0x%0h, expected WrSel=%0d WB=0x%0h",
                   WrSel, WB, e[18:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mem_done = 1'b0; mem_rdata = 16'h0;
    idle();
    step(2);
    chk("rst_WB", WB, 16'h0);
    chk("rst_WrSel", {13'b0, WrSel}, 16'h0);
    chk("rst_RegWrt", {15'b0, RegWrt}, 16'h0);
    chk("rst_stall", {15'b0, wb_stall}, 16'h0);
    chk("rst_halted", {15'b0, halted}, 16'h0);
    chk("rst_err", {15'b0, err}, 16'h0);
    rst = 1'b0;

    // ALU write then bubble
    drive(1, 1, 3'd3, WB_SEL_ALU, 16'h1234, 16'hAAAA, 16'hBBBB, 16'hCCCC, 0, 0);
    expect_wr(3'd3, 16'h1234);
    step(1);
    chk("alu_RegWrt", {15'b0, RegWrt}, 16'h1);
    chk("alu_WrSel", {13'b0, WrSel}, 16'h3);
    chk("alu_WB", WB, 16'h1234);
    idle();
    step(1);
    chk("bubble_RegWrt", {15'b0, RegWrt}, 16'h0);

    // Back-to-back link, immediate, non-writing, and ready load data
    drive(1, 1, 3'd7, WB_SEL_PC, 16'h1111, 16'h2222, 16'h0042, 16'h3333, 0, 0);
    expect_wr(3'd7, 16'h0042);
    step(1);
    chk("link_WB", WB, 16'h0042);
    drive(1, 1, 3'd4, WB_SEL_IMM, 16'h1111, 16'h2222, 16'h0042, 16'hFF80, 0, 0);
    expect_wr(3'd4, 16'hFF80);
    step(1);
    chk("imm_WB", WB, 16'hFF80);
    drive(1, 0, 3'd1, WB_SEL_ALU, 16'h9999, 16'h0, 16'h0, 16'h0, 0, 0);
    step(1);
    chk("nowrite_RegWrt", {15'b0, RegWrt}, 16'h0);
    drive(1, 1, 3'd6, WB_SEL_MEM, 16'h0001, 16'h5A5A, 16'h0002, 16'h0003, 0, 0);
    expect_wr(3'd6, 16'h5A5A);
    step(1);
    chk("memrdy_WB", WB, 16'h5A5A);

    // Late load to R5; next instruction held upstream across the stall
    drive(1, 1, 3'd5, WB_SEL_MEM, 16'h0, 16'h1111, 16'h0, 16'h0, 1, 0);
    step(1);
    drive(1, 1, 3'd2, WB_SEL_ALU, 16'h0202, 16'h0, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("wait_stall", {15'b0, wb_stall}, 16'h1);
      chk("wait_RegWrt", {15'b0, RegWrt}, 16'h0);
      step(1);
    end
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    expect_wr(3'd5, 16'hBEEF);
    expect_wr(3'd2, 16'h0202);
    step(1);
    mem_done = 1'b0; mem_rdata = 16'h0;
    chk("load_stall", {15'b0, wb_stall}, 16'h0);
    chk("load_RegWrt", {15'b0, RegWrt}, 16'h1);
    chk("load_WrSel", {13'b0, WrSel}, 16'h5);
    chk("load_WB", WB, 16'hBEEF);
    step(1);
    idle();
    chk("after_load_WrSel", {13'b0, WrSel}, 16'h2);
    step(1);
    chk("after_load_idle", {15'b0, RegWrt}, 16'h0);
    chk("no_err_yet", {15'b0, err}, 16'h0);

    // HALT retirement holds until reset
    drive(1, 0, 3'd0, WB_SEL_ALU, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);
    step(1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 3'($urandom_range(0, 7)), WB_SEL_ALU, 16'($urandom_range(0, 65535)),
            16'h0, 16'h0, 16'h0, 0, 0);
      chk("halt_halted", {15'b0, halted}, 16'h1);
      chk("halt_stall", {15'b0, wb_stall}, 16'h1);
      chk("halt_RegWrt", {15'b0, RegWrt}, 16'h0);
      step(1);
    end
    idle();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("halt_rst_halted", {15'b0, halted}, 16'h0);
    chk("halt_rst_stall", {15'b0, wb_stall}, 16'h0);

    // mem_done in RUN is a sticky error
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    step(1);
    mem_done = 1'b0;
    chk("stray_done_err", {15'b0, err}, 16'h1);
    drive(1, 1, 3'd1, WB_SEL_ALU, 16'h0001, 16'h0, 16'h0, 16'h0, 0, 0);
    expect_wr(3'd1, 16'h0001);
    step(1);
    idle();
    chk("sticky_WB", WB, 16'h0001);
    step(2);
    chk("sticky_err", {15'b0, err}, 16'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("err_cleared", {15'b0, err}, 16'h0);

    // Reset while waiting for load data discards the write
    drive(1, 1, 3'd6, WB_SEL_MEM, 16'h0, 16'h7777, 16'h0, 16'h0, 1, 0);
    step(1);
    idle();
    chk("rstwait_stall", {15'b0, wb_stall}, 16'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstwait_run", {15'b0, wb_stall}, 16'h0);
    chk("rstwait_RegWrt", {15'b0, RegWrt}, 16'h0);
    step(2);
    chk("rstwait_err", {15'b0, err}, 16'h0);

    // HALT with a pending load is illegal
    drive(1, 0, 3'd0, WB_SEL_ALU, 16'h0, 16'h0, 16'h0, 16'h0, 1, 1);
    step(1);
    idle();
    chk("haltpend_halted", {15'b0, halted}, 16'h1);
    chk("haltpend_err", {15'b0, err}, 16'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

`ifdef WB_TIMEOUT_EN
    // Missing load data times out after TO stall cycles
    drive(1, 1, 3'd7, WB_SEL_MEM, 16'h0, 16'h4444, 16'h0, 16'h0, 1, 0);
    step(1);
    idle();
    for (int i = 0; i < TO; i++) begin
      chk("to_stall", {15'b0, wb_stall}, 16'h1);
      chk("to_err_low", {15'b0, err}, 16'h0);
      step(1);
    end
    chk("to_run", {15'b0, wb_stall}, 16'h0);
    chk("to_err", {15'b0, err}, 16'h1);
    chk("to_RegWrt", {15'b0, RegWrt}, 16'h0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
`endif

    step(2);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
